prog_loader: RTL and testbench

- Boot-time program loader upstream of the single-cycle RISC-V top.
- Holds the core in reset while a byte stream (e.g. from a UART receiver) is assembled into 32-bit words and written into instruction memory from word address 0.
- Verifies a trailing XOR checksum, then releases the core's active-low reset.
- On error the core stays in reset and the error is flagged.

---
 rtl/rv_boot_pkg.sv | 20 ++
 rtl/byte_assembler.sv | 50 +++++
 rtl/prog_loader.sv | 155 +++++++++++++++
 tb/tb_prog_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_boot_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding and stream framing constants.
package rv_boot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StLoad,
        StChk,
        StRun,
        StErr
    } state_e;

    localparam int unsigned BytesPerWord    = 4;
    localparam int unsigned DefaultCntWidth = 16;

    function automatic int unsigned hdr_bytes(input int unsigned cnt_width);
        return cnt_width / 8;
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Shifts little-endian bytes into a word and pulses word_valid_o on the last byte of each group.
module byte_assembler
    import rv_boot_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    input  logic [2:0]  nbytes_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] shifted;
    logic [5:0]  align;
    logic        last;

    always_comb begin
        shifted = {byte_i, word_q[31:8]};
        // Right-align short groups (e.g. a 2-byte header) so the value sits in the low bits.
        align   = {3'(3'(BytesPerWord) - nbytes_i), 3'b000};
        word_o  = shifted >> align;
        last    = (cnt_q == nbytes_i - 3'd1);
        word_valid_o = byte_valid_i && last && !clear_i;

        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d  = 3'd0;
            word_d = 32'd0;
        end else if (byte_valid_i) begin
            word_d = shifted;
            cnt_d  = last ? 3'd0 : cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 3'd0;
            word_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: assembles a framed byte stream into instruction memory, verifies the XOR
// checksum and only then releases the core's active-low reset.
module prog_loader
    import rv_boot_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = DefaultCntWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  s_valid_i,
    input  logic [7:0]            s_data_i,
    output logic                  s_ready_o,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    output logic                  core_rst_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [CNT_WIDTH:0] MaxWords  = (CNT_WIDTH + 1)'(1) << ADDR_WIDTH;
    localparam logic [2:0]         HdrNbytes = 3'(hdr_bytes(CNT_WIDTH));
    localparam logic [2:0]         WordBytes = 3'(BytesPerWord);

    state_e state_q, state_d;

    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  idx_q, idx_d;
    logic [7:0]            csum_q, csum_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  core_rst_q;

    logic                  xfer;
    logic                  restart;
    logic                  asm_valid;
    logic [2:0]            asm_nbytes;
    logic [31:0]           asm_word;
    logic                  word_valid;
    logic [CNT_WIDTH-1:0]  hdr_count;
    logic                  last_word;

    assign xfer       = s_valid_i && s_ready_o;
    assign restart    = start_i && (state_q inside {StIdle, StRun, StErr});
    assign asm_valid  = xfer && (state_q inside {StHdr, StLoad});
    assign asm_nbytes = (state_q == StHdr) ? HdrNbytes : WordBytes;
    assign hdr_count  = asm_word[CNT_WIDTH-1:0];
    assign last_word  = ((idx_q + CNT_WIDTH'(1)) == count_q);

    byte_assembler u_byte_assembler (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (restart),
        .byte_valid_i (asm_valid),
        .byte_i       (s_data_i),
        .nbytes_i     (asm_nbytes),
        .word_o       (asm_word),
        .word_valid_o (word_valid)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            core_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            core_rst_q <= (state_d == StRun);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StRun, StErr: begin
                if (start_i) state_d = StHdr;
            end
            StHdr: begin
                if (word_valid) begin
                    if ({1'b0, hdr_count} > MaxWords) state_d = StErr;
                    else if (hdr_count == '0)         state_d = StChk;
                    else                              state_d = StLoad;
                end
            end
            StLoad: begin
                if (word_valid && last_word) state_d = StChk;
            end
            StChk: begin
                if (xfer) state_d = (s_data_i == csum_q) ? StRun : StErr;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        s_ready_o  = state_q inside {StHdr, StLoad, StChk};
        busy_o     = state_q inside {StHdr, StLoad, StChk};
        done_o     = (state_q == StRun);
        err_o      = (state_q == StErr);
        core_rst_o = core_rst_q;
    end

    always_comb begin
        count_d = count_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (restart) begin
            count_d = '0;
            idx_d   = '0;
            csum_d  = 8'd0;
        end else begin
            if (asm_valid) csum_d = csum_q ^ s_data_i;
            if (state_q == StHdr && word_valid) count_d = hdr_count;
            // Write lands the cycle after the 4th byte; may overlap the first CHK cycle.
            if (state_q == StLoad && word_valid) begin
                we_d    = 1'b1;
                addr_d  = idx_q[ADDR_WIDTH-1:0];
                wdata_d = asm_word;
                idx_d   = idx_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            idx_q   <= '0;
            csum_q  <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            count_q <= count_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a stream-level reference model.
module tb_prog_loader;

    localparam int unsigned AW       = 10;
    localparam int          MaxWords = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'd0;
    logic          s_ready, imem_we, core_rst, busy, done, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  stim_q[$];
    logic [31:0] exp_q[$];
    bit          exp_ok;
    bit          hdr_only;
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    prog_loader #(
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .s_valid_i    (s_valid),
        .s_data_i     (s_data),
        .s_ready_o    (s_ready),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_wdata_o (imem_wdata),
        .core_rst_o   (core_rst),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(int'(imem_addr));
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_status(input string tag, input bit e_core, input bit e_busy,
                                input bit e_done, input bit e_err, input bit e_ready);
        check_eq({tag, ".core_rst"}, 32'(core_rst), 32'(e_core));
        check_eq({tag, ".busy"},     32'(busy),     32'(e_busy));
        check_eq({tag, ".done"},     32'(done),     32'(e_done));
        check_eq({tag, ".err"},      32'(err),      32'(e_err));
        check_eq({tag, ".s_ready"},  32'(s_ready),  32'(e_ready));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_status(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq({tag, ".imem_we"},    32'(imem_we),   32'd0);
        check_eq({tag, ".imem_addr"},  32'(imem_addr), 32'd0);
        check_eq({tag, ".imem_wdata"}, imem_wdata,     32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte after an optional idle gap; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int waited;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = b;
        waited  = 0;
        while (!s_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            check_eq("send_timeout", 32'd1, 32'd0);
        end else begin
            @(negedge clk);
        end
    endtask

    // Reference model: frame a stream from a word count and decide the expected outcome.
    task automatic build_stream(input int count, input bit bad);
        logic [15:0] c16;
        logic [31:0] w;
        logic [7:0]  x;
        stim_q.delete();
        exp_q.delete();
        c16 = 16'(count);
        stim_q.push_back(c16[7:0]);
        stim_q.push_back(c16[15:8]);
        x = c16[7:0] ^ c16[15:8];
        if (count > MaxWords) begin
            hdr_only = 1'b1;
            exp_ok   = 1'b0;
        end else begin
            hdr_only = 1'b0;
            for (int i = 0; i < count; i++) begin
                w = $urandom;
                exp_q.push_back(w);
                for (int k = 0; k < 4; k++) begin
                    stim_q.push_back(w[8*k +: 8]);
                    x = x ^ w[8*k +: 8];
                end
            end
            stim_q.push_back(bad ? (x ^ 8'h01) : x);
            exp_ok = !bad;
        end
    endtask

    task automatic load_two_word(input logic [7:0] last);
        stim_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, last};
        exp_q  = '{32'h0050_0093, 32'h0010_0113};
        exp_ok   = (last == 8'hC3);
        hdr_only = 1'b0;
    endtask

    task automatic run_stream(input string tag, input int max_gap);
        int n;
        s_valid = 1'b0;
        pulse_start();
        wr_addr_q.delete();
        wr_data_q.delete();
        check_status({tag, ".hdr"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        n = stim_q.size();
        for (int i = 0; i < n - 1; i++) send_byte(stim_q[i], max_gap);
        if (hdr_only) begin
            send_byte(stim_q[n-1], max_gap);
            s_valid = 1'b0;
            check_status({tag, ".oversize"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end else begin
            check_eq({tag, ".pre_core_rst"}, 32'(core_rst), 32'd0);
            send_byte(stim_q[n-1], max_gap);
            s_valid = 1'b0;
            if (exp_ok) check_status({tag, ".run"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            else        check_status({tag, ".err"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        repeat (3) @(negedge clk);
        check_eq({tag, ".n_writes"}, 32'(wr_addr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
            check_eq({tag, ".addr"}, 32'(wr_addr_q[i]), 32'(i));
            check_eq({tag, ".data"}, wr_data_q[i], exp_q[i]);
        end
        check_eq({tag, ".hold_core_rst"}, 32'(core_rst), 32'(exp_ok));
    endtask

    initial begin
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle");

        load_two_word(8'hC3);
        run_stream("two_word", 0);

        build_stream(0, 1'b0);
        run_stream("zero_len", 0);

        load_two_word(8'hC2);
        run_stream("bad_csum", 0);
        pulse_start();
        check_status("after_err_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        // Abandon that load cleanly.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        stim_q   = '{8'h01, 8'h04};
        exp_q.delete();
        hdr_only = 1'b1;
        exp_ok   = 1'b0;
        run_stream("oversize_1025", 0);

        load_two_word(8'hC3);
        run_stream("backpressure", 3);

        // Reset mid-load after the 6th byte.
        load_two_word(8'hC3);
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(stim_q[i], 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_stream("after_reset", 1);

        // Restart from RUN.
        pulse_start();
        check_status("restart_run", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        load_two_word(8'hC3);
        run_stream("pre_restart", 0);
        build_stream(3, 1'b0);
        run_stream("restart_reload", 2);

        for (int t = 0; t < 8; t++) begin
            build_stream(int'($urandom_range(8, 0)), ($urandom_range(3, 0) == 0));
            run_stream("random", 3);
        end

        build_stream(MaxWords, 1'b0);
        run_stream("full_mem", 0);
        build_stream(MaxWords + 1, 1'b0);
        run_stream("oversize_rand", 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
